pipelined_datapath: RTL

PIPELINED_DATAPATH -- requirements
Module: pipelined_datapath

---
 rtl/pipelined_datapath.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - two-stage execute/writeback datapath with forwarding, register file and data memory
module pipelined_datapath #(
    parameter int DATA_W = 16,
    parameter int RF_AW  = 4,
    parameter int DM_AW  = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [RF_AW-1:0]  RF_Ra_Addr,
    input  logic [RF_AW-1:0]  RF_Rb_Addr,
    input  logic [RF_AW-1:0]  RF_W_Addr,
    input  logic              RF_W_en,
    input  logic [2:0]        ALU_s,
    input  logic [1:0]        WB_s,
    input  logic              D_Wr,
    input  logic [DM_AW-1:0]  D_Addr,
    input  logic [DATA_W-1:0] Imm,
    output logic [DATA_W-1:0] ALU_inA,
    output logic [DATA_W-1:0] ALU_inB,
    output logic [DATA_W-1:0] ALU_out,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] WB_data,
    output logic              Zero,
    output logic              Carry
);
    localparam int RF_DEPTH = 2 ** RF_AW;
    localparam int DM_DEPTH = 2 ** DM_AW;

    logic [DATA_W-1:0] rf_q [RF_DEPTH];
    logic [DATA_W-1:0] rf_d [RF_DEPTH];
    logic [DATA_W-1:0] dm_q [DM_DEPTH];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [1:0]        wb_s_q, wb_s_d;
    logic              we_q, we_d;
    logic [RF_AW-1:0]  waddr_q, waddr_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;

    logic              accept;
    logic              rf_we;
    logic              alu_c;
    logic [DATA_W:0]   sum;

    assign In_ready  = !out_valid_q || Out_ready;
    assign accept    = In_valid && In_ready;
    assign rf_we     = out_valid_q && Out_ready && we_q;
    assign Out_valid = out_valid_q;
    assign Zero      = zero_q;
    assign Carry     = carry_q;

    // The writeback-stage value is visible only while Out_valid is set.
    always_comb begin
        ALU_inA = rf_q[RF_Ra_Addr];
        ALU_inB = rf_q[RF_Rb_Addr];
        if (out_valid_q && we_q && (waddr_q == RF_Ra_Addr)) ALU_inA = WB_data;
        if (out_valid_q && we_q && (waddr_q == RF_Rb_Addr)) ALU_inB = WB_data;
    end

    always_comb begin
        sum     = '0;
        ALU_out = '0;
        alu_c   = 1'b0;
        case (ALU_s)
            3'b000: begin
                sum     = {1'b0, ALU_inA} + {1'b0, ALU_inB};
                ALU_out = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            3'b001: begin
                ALU_out = ALU_inA - ALU_inB;
                alu_c   = ALU_inA < ALU_inB;
            end
            3'b010: ALU_out = ALU_inA & ALU_inB;
            3'b011: ALU_out = ALU_inA | ALU_inB;
            3'b100: ALU_out = ALU_inA ^ ALU_inB;
            3'b101: ALU_out = ~ALU_inA;
            3'b110: begin
                ALU_out = {ALU_inA[DATA_W-2:0], 1'b0};
                alu_c   = ALU_inA[DATA_W-1];
            end
            default: begin
                ALU_out = {1'b0, ALU_inA[DATA_W-1:1]};
                alu_c   = ALU_inA[0];
            end
        endcase
    end

    always_comb begin
        case (wb_s_q)
            2'b01:   WB_data = rd_q;
            2'b10:   WB_data = imm_q;
            default: WB_data = alu_q;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        alu_d       = alu_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        wb_s_d      = wb_s_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        if (accept) begin
            out_valid_d = 1'b1;
            alu_d       = ALU_out;
            imm_d       = Imm;
            rd_d        = dm_q[D_Addr];
            wb_s_d      = WB_s;
            we_d        = RF_W_en;
            waddr_d     = RF_W_Addr;
            zero_d      = (ALU_out == '0);
            carry_d     = alu_c;
        end else if (Out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (rf_we) rf_d[waddr_q] = WB_data;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            alu_q       <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            wb_s_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_q       <= alu_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            wb_s_q      <= wb_s_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            rf_q        <= rf_d;
        end
    end

    // Memory array is intentionally not reset; the read port above sees the pre-write word.
    always_ff @(posedge Clock) begin
        if (accept && D_Wr) dm_q[D_Addr] <= ALU_inA;
    end
endmodule
